bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter BIOS_WP, default 1: 1 = writes to the BIOS region are suppressed.
REQ-002 clock  in  1  single system clock; all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 cpu_req/cpu_we  in  1/1  CPU request and write qualifier.
REQ-005 cpu_addr/cpu_wdata  in  20/8  CPU byte address and write data.
REQ-006 cpu_rdata/cpu_ack  out  8/1  CPU read data and one-cycle completion pulse.
REQ-007 dma_req/dma_we/dma_addr/dma_wdata/dma_rdata/dma_ack  in/in/in/in/out/out  1/1/20/8/8/1  DMA port, identical semantics to the CPU port.
REQ-008 bus_addr/bus_wdata  out  20/8  shared address and data to all memories.
REQ-009 we_memory/we_cgamem/we_bios  out  1 each  per-region write strobes.
REQ-010 q_memory/q_cgamem/q_bios  in  8 each  registered BRAM outputs, one-cycle read latency.
REQ-011 grant  out  2  one-hot owner {dma,cpu}; 00 when idle.

Function
REQ-012 FSM states IDLE, ACCESS, WAIT, RESPOND; transitions IDLE->ACCESS on any sampled req, ACCESS->WAIT->RESPOND unconditionally, RESPOND->IDLE.
REQ-013 In IDLE the winner's addr/we/wdata are latched at the edge entering ACCESS and held on bus_addr/bus_wdata through RESPOND.
REQ-014 Decode: 00xxxx_... (00000-3FFFF) memory; B8000-B9FFF cgamem; F0000-F1FFF bios; all else unmapped.
REQ-015 Region write strobe is high during ACCESS only, for exactly one cycle, and only when latched we=1.
REQ-016 At the edge leaving WAIT, the selected q is captured into the winner's rdata; unmapped captures 8'hFF.
REQ-017 Winner's ack is high during RESPOND only; the loser's ack and rdata are unchanged.
REQ-018 Latency: req sampled at edge N -> ack high in cycle N+3; peak throughput one transaction per 4 cycles.
REQ-019 Single requester is granted directly; simultaneous requests go round-robin to the port not granted last.
REQ-020 Requester holds req/addr/we/wdata until ack; req still high in IDLE after ack starts a new transaction.
REQ-021 Req dropped before ack: transaction completes, ack still pulses.
REQ-022 Write to the BIOS region with BIOS_WP=1: no strobe, ack still pulses; write to unmapped: no strobe, ack pulses.
REQ-023 Reads return rdata for writes as well (captured q of the addressed region).

Reset
REQ-024 Reset forces IDLE, grant=00, all we_*=0, both ack=0, both rdata=8'h00, bus_addr=0, bus_wdata=0, last-grant=DMA (CPU wins the first tie).
REQ-025 Reset mid-transaction aborts it with no ack and no further strobe; requester reissues.

Structure
REQ-026 Shared package holds region base/mask constants and the FSM state encoding.
REQ-027 One natural sub-module, bus_decode: combinational address -> region select; everything else in bus_arbiter.

Verification
REQ-028 CPU write 0x12345 data 0xA5, then read -> we_memory one cycle in ACCESS, read ack in N+3 with cpu_rdata=0xA5.
REQ-029 CPU and DMA request same edge after reset -> CPU acked first, DMA next; with both held continuously, grants alternate CPU,DMA,CPU.
REQ-030 Read 0xC0000 -> cpu_rdata=0xFF, no strobe, ack pulses.
REQ-031 DMA write 0xF0010 data 0x55, BIOS_WP=1 -> we_bios never high, dma_ack pulses; BIOS_WP=0 -> we_bios pulses once.
REQ-032 DMA write 0xB8000 data 0x41 -> we_cgamem pulses once with bus_addr=0xB8000 and bus_wdata=0x41.
REQ-033 Reset asserted in WAIT -> immediate IDLE, all outputs at reset values, no ack; a reissued request completes normally.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the two-port memory bus arbiter: region windows,
// FSM state encoding and region select encoding.
package bus_arbiter_pkg;

    localparam int ADDR_W = 20;
    localparam int DATA_W = 8;

    // A region matches when (addr & mask) == base
    localparam logic [ADDR_W-1:0] MEM_BASE  = 20'h00000;
    localparam logic [ADDR_W-1:0] MEM_MASK  = 20'hC0000;
    localparam logic [ADDR_W-1:0] CGA_BASE  = 20'hB8000;
    localparam logic [ADDR_W-1:0] CGA_MASK  = 20'hFE000;
    localparam logic [ADDR_W-1:0] BIOS_BASE = 20'hF0000;
    localparam logic [ADDR_W-1:0] BIOS_MASK = 20'hFE000;

    localparam logic [DATA_W-1:0] UNMAPPED_DATA = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_WAIT,
        ST_RESPOND
    } state_t;

    typedef enum logic [1:0] {
        RGN_NONE,
        RGN_MEM,
        RGN_CGA,
        RGN_BIOS
    } region_t;

    function automatic logic in_region(input logic [ADDR_W-1:0] addr,
                                       input logic [ADDR_W-1:0] base,
                                       input logic [ADDR_W-1:0] mask);
        return (addr & mask) == base;
    endfunction

endpackage

// File: rtl/bus_decode.sv
// Combinational address decoder: maps a bus byte address to its region.
module bus_decode
    import bus_arbiter_pkg::*;
(
    input  logic [ADDR_W-1:0] addr,
    output region_t           region
);

    always_comb begin
        region = RGN_NONE;
        if (in_region(addr, MEM_BASE, MEM_MASK))
            region = RGN_MEM;
        else if (in_region(addr, CGA_BASE, CGA_MASK))
            region = RGN_CGA;
        else if (in_region(addr, BIOS_BASE, BIOS_MASK))
            region = RGN_BIOS;
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-port (CPU/DMA) round-robin arbiter in front of three BRAM regions.
// Each transaction takes IDLE->ACCESS->WAIT->RESPOND, one beat per state.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter bit BIOS_WP = 1'b1
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,

    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_ack,

    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              we_memory,
    output logic              we_cgamem,
    output logic              we_bios,

    input  logic [DATA_W-1:0] q_memory,
    input  logic [DATA_W-1:0] q_cgamem,
    input  logic [DATA_W-1:0] q_bios,

    output logic [1:0]        grant
);

    state_t            state, state_nx;
    region_t           region;
    logic              owner_dma;   // owner of the current/last transaction
    logic              lat_we;
    logic              pick_dma;
    logic              any_req;
    logic [DATA_W-1:0] rd_sel;

    bus_decode u_decode (
        .addr   (bus_addr),
        .region (region)
    );

    assign any_req  = cpu_req | dma_req;
    // On a tie the port that did not own the last transaction wins
    assign pick_dma = dma_req & (~cpu_req | ~owner_dma);

    always_comb begin
        rd_sel = UNMAPPED_DATA;
        case (region)
            RGN_MEM:  rd_sel = q_memory;
            RGN_CGA:  rd_sel = q_cgamem;
            RGN_BIOS: rd_sel = q_bios;
            default:  rd_sel = UNMAPPED_DATA;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            owner_dma <= 1'b1;
            lat_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            state <= state_nx;
            if (state == ST_IDLE && any_req) begin
                owner_dma <= pick_dma;
                lat_we    <= pick_dma ? dma_we    : cpu_we;
                bus_addr  <= pick_dma ? dma_addr  : cpu_addr;
                bus_wdata <= pick_dma ? dma_wdata : cpu_wdata;
            end
            // BRAM q is valid in WAIT: address was presented during ACCESS
            if (state == ST_WAIT) begin
                if (owner_dma) dma_rdata <= rd_sel;
                else           cpu_rdata <= rd_sel;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        grant     = 2'b00;
        we_memory = 1'b0;
        we_cgamem = 1'b0;
        we_bios   = 1'b0;
        cpu_ack   = 1'b0;
        dma_ack   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) state_nx = ST_ACCESS;
            end
            ST_ACCESS: begin
                state_nx  = ST_WAIT;
                grant     = {owner_dma, ~owner_dma};
                we_memory = lat_we & (region == RGN_MEM);
                we_cgamem = lat_we & (region == RGN_CGA);
                we_bios   = lat_we & (region == RGN_BIOS) & ~BIOS_WP;
            end
            ST_WAIT: begin
                state_nx = ST_RESPOND;
                grant    = {owner_dma, ~owner_dma};
            end
            ST_RESPOND: begin
                state_nx = ST_IDLE;
                grant    = {owner_dma, ~owner_dma};
                cpu_ack  = ~owner_dma;
                dma_ack  = owner_dma;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, tie/alternation,
// dropped request, reset during WAIT, and randomized traffic against a model.
module tb_bus_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [19:0] cpu_addr, dma_addr;
    logic [7:0]  cpu_wdata, dma_wdata;
    logic [7:0]  q_memory, q_cgamem, q_bios;

    logic [7:0]  cpu_rdata, dma_rdata;
    logic        cpu_ack, dma_ack;
    logic [19:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        we_memory, we_cgamem, we_bios;
    logic [1:0]  grant;

    // Second instance with BIOS writes enabled, sharing inputs and read data
    logic [7:0]  n_cpu_rdata, n_dma_rdata;
    logic        n_cpu_ack, n_dma_ack;
    logic [19:0] n_bus_addr;
    logic [7:0]  n_bus_wdata;
    logic        n_we_memory, n_we_cgamem, n_we_bios;
    logic [1:0]  n_grant;

    always #5 clock = ~clock;

    bus_arbiter dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata), .dma_ack(dma_ack),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .we_memory(we_memory), .we_cgamem(we_cgamem), .we_bios(we_bios),
        .q_memory(q_memory), .q_cgamem(q_cgamem), .q_bios(q_bios),
        .grant(grant)
    );

    bus_arbiter #(.BIOS_WP(1'b0)) dut_nwp (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(n_cpu_rdata), .cpu_ack(n_cpu_ack),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(n_dma_rdata), .dma_ack(n_dma_ack),
        .bus_addr(n_bus_addr), .bus_wdata(n_bus_wdata),
        .we_memory(n_we_memory), .we_cgamem(n_we_cgamem), .we_bios(n_we_bios),
        .q_memory(q_memory), .q_cgamem(q_cgamem), .q_bios(q_bios),
        .grant(n_grant)
    );

    // Read-first BRAM models driven by the write-protected instance
    logic [7:0] mem_arr  [0:262143];
    logic [7:0] cga_arr  [0:8191];
    logic [7:0] bios_arr [0:8191];

    initial begin
        for (int i = 0; i < 262144; i++) mem_arr[i] = 8'h00;
        for (int i = 0; i < 8192; i++) begin
            cga_arr[i]  = 8'h00;
            bios_arr[i] = 8'h00;
        end
    end

    always @(posedge clock) begin
        q_memory <= mem_arr[bus_addr[17:0]];
        q_cgamem <= cga_arr[bus_addr[12:0]];
        q_bios   <= bios_arr[bus_addr[12:0]];
        if (we_memory) mem_arr[bus_addr[17:0]]  <= bus_wdata;
        if (we_cgamem) cga_arr[bus_addr[12:0]]  <= bus_wdata;
        if (we_bios)   bios_arr[bus_addr[12:0]] <= bus_wdata;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Reference model: address ranges, sparse memory image, default contents 0
    logic [7:0] mdl [logic [19:0]];

    function automatic int rgn(input logic [19:0] a);
        if (a <= 20'h3FFFF) return 1;
        if (a >= 20'hB8000 && a <= 20'hB9FFF) return 2;
        if (a >= 20'hF0000 && a <= 20'hF1FFF) return 3;
        return 0;
    endfunction

    task automatic model_txn(input logic we, input logic [19:0] a, input logic [7:0] wd,
                             output logic [7:0] rd, output logic [2:0] strb, output logic [2:0] nstrb);
        int r;
        r = rgn(a);
        rd = (r == 0) ? 8'hFF : (mdl.exists(a) ? mdl[a] : 8'h00);
        strb = 3'b000;
        nstrb = 3'b000;
        if (we && r != 0) begin
            nstrb = 3'(1 << (r - 1));
            if (r != 3) begin
                strb = nstrb;
                mdl[a] = wd;
            end
        end
    endtask

    logic [7:0]  t_rd, t_nrd;
    int          t_lat, t_nlat, t_strb_at;
    logic [2:0]  t_strb, t_nstrb;
    logic [1:0]  t_grant, t_ngrant;
    logic [19:0] t_saddr, t_nsaddr;
    logic [7:0]  t_swd, t_nswd;
    logic        t_other_bad;

    task automatic run_txn(input logic dma, input logic we, input logic [19:0] a,
                           input logic [7:0] wd, input logic hold_one);
        logic [7:0] other0;
        logic [2:0] s, ns;
        @(posedge clock); #1;
        if (dma) begin
            dma_req = 1'b1; dma_we = we; dma_addr = a; dma_wdata = wd;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        end
        other0 = dma ? cpu_rdata : dma_rdata;
        t_rd = 8'h00; t_nrd = 8'h00; t_lat = 0; t_nlat = 0; t_strb_at = 0;
        t_strb = 3'b000; t_nstrb = 3'b000; t_grant = 2'b00; t_ngrant = 2'b00;
        t_saddr = '0; t_nsaddr = '0; t_swd = '0; t_nswd = '0; t_other_bad = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clock);
            s  = {we_bios, we_cgamem, we_memory};
            ns = {n_we_bios, n_we_cgamem, n_we_memory};
            if (|s) begin
                t_strb |= s; t_strb_at = i; t_saddr = bus_addr; t_swd = bus_wdata;
            end
            if (|ns) begin
                t_nstrb |= ns; t_nsaddr = n_bus_addr; t_nswd = n_bus_wdata;
            end
            if ((dma ? cpu_ack : dma_ack) || (dma ? cpu_rdata : dma_rdata) !== other0)
                t_other_bad = 1'b1;
            if (dma ? n_dma_ack : n_cpu_ack) begin
                t_nlat = i; t_nrd = dma ? n_dma_rdata : n_cpu_rdata; t_ngrant = n_grant;
            end
            if (hold_one && i == 2) begin
                if (dma) dma_req = 1'b0; else cpu_req = 1'b0;
            end
            if (dma ? dma_ack : cpu_ack) begin
                t_lat = i; t_rd = dma ? dma_rdata : cpu_rdata; t_grant = grant;
                break;
            end
        end
        @(posedge clock); #1;
        cpu_req = 1'b0;
        dma_req = 1'b0;
    endtask

    task automatic check_txn(input string nm, input logic dma, input logic [19:0] a,
                             input logic [7:0] wd, input logic [7:0] rd,
                             input logic [2:0] strb, input logic [2:0] nstrb);
        chk({nm, " latency"}, t_lat, 4);
        chk({nm, " rdata"}, t_rd, rd);
        chk({nm, " strobes"}, t_strb, strb);
        chk({nm, " grant"}, t_grant, dma ? 2'b10 : 2'b01);
        chk({nm, " loser untouched"}, t_other_bad, 0);
        chk({nm, " nwp latency"}, t_nlat, 4);
        chk({nm, " nwp rdata"}, t_nrd, rd);
        chk({nm, " nwp strobes"}, t_nstrb, nstrb);
        chk({nm, " nwp grant"}, t_ngrant, dma ? 2'b10 : 2'b01);
        if (strb != 3'b000) begin
            chk({nm, " strobe cycle"}, t_strb_at, 2);
            chk({nm, " strobe addr"}, t_saddr, a);
            chk({nm, " strobe data"}, t_swd, wd);
        end
        if (nstrb != 3'b000) begin
            chk({nm, " nwp strobe addr"}, t_nsaddr, a);
            chk({nm, " nwp strobe data"}, t_nswd, wd);
        end
    endtask

    typedef struct {
        logic        dma;
        logic        we;
        logic [19:0] addr;
        logic [7:0]  wd;
        logic [7:0]  rd;
        logic [2:0]  strb;   // {bios, cga, mem} on the write-protected instance
        logic [2:0]  nstrb;  // same, with BIOS writes enabled
    } vec_t;

    vec_t tbl [17];

    logic [19:0] pool [12];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0] erd;
        logic [2:0] es, ens;
        int order [4];
        int at [4];
        int nacks, bad;
        logic dma, we;
        logic [19:0] a;
        logic [7:0] wd;

        tbl[0]  = '{1'b0, 1'b1, 20'h12345, 8'hA5, 8'h00, 3'b001, 3'b001};
        tbl[1]  = '{1'b0, 1'b0, 20'h12345, 8'h00, 8'hA5, 3'b000, 3'b000};
        tbl[2]  = '{1'b0, 1'b0, 20'hC0000, 8'h00, 8'hFF, 3'b000, 3'b000};
        tbl[3]  = '{1'b1, 1'b1, 20'hF0010, 8'h55, 8'h00, 3'b000, 3'b100};
        tbl[4]  = '{1'b1, 1'b0, 20'hF0010, 8'h00, 8'h00, 3'b000, 3'b000};
        tbl[5]  = '{1'b1, 1'b1, 20'hB8000, 8'h41, 8'h00, 3'b010, 3'b010};
        tbl[6]  = '{1'b1, 1'b0, 20'hB8000, 8'h00, 8'h41, 3'b000, 3'b000};
        tbl[7]  = '{1'b0, 1'b1, 20'h3FFFF, 8'h7E, 8'h00, 3'b001, 3'b001};
        tbl[8]  = '{1'b0, 1'b0, 20'h3FFFF, 8'h00, 8'h7E, 3'b000, 3'b000};
        tbl[9]  = '{1'b0, 1'b1, 20'h40000, 8'hC3, 8'hFF, 3'b000, 3'b000};
        tbl[10] = '{1'b1, 1'b1, 20'hB9FFF, 8'h99, 8'h00, 3'b010, 3'b010};
        tbl[11] = '{1'b0, 1'b0, 20'hB9FFF, 8'h00, 8'h99, 3'b000, 3'b000};
        tbl[12] = '{1'b0, 1'b0, 20'hBA000, 8'h00, 8'hFF, 3'b000, 3'b000};
        tbl[13] = '{1'b1, 1'b0, 20'hF1FFF, 8'h00, 8'h00, 3'b000, 3'b000};
        tbl[14] = '{1'b0, 1'b0, 20'hF2000, 8'h00, 8'hFF, 3'b000, 3'b000};
        tbl[15] = '{1'b1, 1'b0, 20'hB7FFF, 8'h00, 8'hFF, 3'b000, 3'b000};
        tbl[16] = '{1'b0, 1'b0, 20'h00000, 8'h00, 8'h00, 3'b000, 3'b000};

        pool = '{20'h00000, 20'h00007, 20'h12345, 20'h3FFFF, 20'hB8000, 20'hB8123,
                 20'hB9FFF, 20'hF0000, 20'hF1FFF, 20'h40000, 20'hBA000, 20'hFFFFF};

        reset = 1'b1;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset grant", grant, 2'b00);
        chk("reset strobes", {we_bios, we_cgamem, we_memory}, 3'b000);
        chk("reset acks", {dma_ack, cpu_ack}, 2'b00);
        chk("reset cpu_rdata", cpu_rdata, 8'h00);
        chk("reset dma_rdata", dma_rdata, 8'h00);
        chk("reset bus_addr", bus_addr, 20'h0);
        chk("reset bus_wdata", bus_wdata, 8'h00);

        // Tie right after reset with both requests held: CPU, DMA, CPU, DMA
        @(posedge clock); #1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010;
        dma_req = 1; dma_we = 0; dma_addr = 20'hB8010;
        nacks = 0; bad = 0;
        for (int i = 0; i < 4; i++) begin order[i] = 0; at[i] = 0; end
        for (int i = 1; i <= 40 && nacks < 4; i++) begin
            @(negedge clock);
            if (cpu_ack && dma_ack) bad = 1;
            if (cpu_ack || dma_ack) begin
                order[nacks] = cpu_ack ? 1 : 2;
                at[nacks] = i;
                nacks++;
            end
        end
        @(posedge clock); #1;
        cpu_req = 0; dma_req = 0;
        chk("tie ack 0 owner", order[0], 1);
        chk("tie ack 1 owner", order[1], 2);
        chk("tie ack 2 owner", order[2], 1);
        chk("tie ack 3 owner", order[3], 2);
        chk("tie first ack cycle", at[0], 4);
        chk("tie ack spacing", at[3] - at[0], 12);
        chk("tie dual ack", bad, 0);

        for (int i = 0; i < 17; i++) begin
            run_txn(tbl[i].dma, tbl[i].we, tbl[i].addr, tbl[i].wd, 1'b0);
            check_txn($sformatf("tbl%0d", i), tbl[i].dma, tbl[i].addr, tbl[i].wd,
                      tbl[i].rd, tbl[i].strb, tbl[i].nstrb);
            model_txn(tbl[i].we, tbl[i].addr, tbl[i].wd, erd, es, ens);
        end

        // Request withdrawn right after being sampled still completes
        model_txn(1'b0, 20'h12345, 8'h00, erd, es, ens);
        run_txn(1'b0, 1'b0, 20'h12345, 8'h00, 1'b1);
        check_txn("dropped req", 1'b0, 20'h12345, 8'h00, erd, es, ens);

        // Reset while in WAIT: the write strobe already fired in ACCESS
        @(posedge clock); #1;
        cpu_req = 1; cpu_we = 1; cpu_addr = 20'h00100; cpu_wdata = 8'h77;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        cpu_req = 0;
        #1;
        chk("rst-wait grant", grant, 2'b00);
        chk("rst-wait strobes", {we_bios, we_cgamem, we_memory}, 3'b000);
        chk("rst-wait acks", {dma_ack, cpu_ack}, 2'b00);
        chk("rst-wait cpu_rdata", cpu_rdata, 8'h00);
        chk("rst-wait dma_rdata", dma_rdata, 8'h00);
        chk("rst-wait bus_addr", bus_addr, 20'h0);
        chk("rst-wait bus_wdata", bus_wdata, 8'h00);
        @(posedge clock); #1 reset = 1'b0;
        bad = 0;
        repeat (8) begin
            @(negedge clock);
            if (cpu_ack || dma_ack || we_memory || we_cgamem || we_bios) bad = 1;
        end
        chk("rst-wait no ack/strobe", bad, 0);
        mdl[20'h00100] = 8'h77;
        model_txn(1'b0, 20'h00100, 8'h00, erd, es, ens);
        run_txn(1'b0, 1'b0, 20'h00100, 8'h00, 1'b0);
        check_txn("reissue", 1'b0, 20'h00100, 8'h00, erd, es, ens);

        for (int n = 0; n < 150; n++) begin
            dma = 1'($urandom_range(0, 1));
            we  = 1'($urandom_range(0, 1));
            a   = ($urandom_range(0, 7) == 0) ? 20'($urandom) : pool[$urandom_range(0, 11)];
            wd  = 8'($urandom);
            model_txn(we, a, wd, erd, es, ens);
            run_txn(dma, we, a, wd, 1'b0);
            check_txn($sformatf("rnd%0d", n), dma, a, wd, erd, es, ens);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
